mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_load_align.sv | 32 +++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store access controller: access sizes,
// FSM states, bus direction and the byte-lane offset width helper.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    BUS_RD = 1'b0,
    BUS_WR = 1'b1
  } bus_dir_e;

  // Number of address bits that select a byte lane within one bus word.
  function automatic int off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Right-aligns the addressed bytes of a bus word and zero/sign-extends them
// to the full data width.
module load_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = 2
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [OFF_W-1:0]      off,
  input  size_e                 size,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] top_bit;
  logic [7:0]            nbits;
  logic                  msb;

  always_comb begin
    sh      = rdata >> {off, 3'b000};
    nbits   = 8'd8 << size;
    // A shift by the full width yields zero, so dword on a 64-bit bus keeps all bits.
    mask    = ~({DATA_WIDTH{1'b1}} << nbits);
    top_bit = mask & ~(mask >> 1);
    msb     = |(sh & top_bit);
    data    = (sh & mask) | ((sign && msb) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: accepts one access from ID/EX, checks alignment,
// runs a single bus transaction with timeout, and returns aligned load data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic                    req_sign,
  input  logic [1:0]              req_size,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    flush,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH/8-1:0] bus_sel,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_ack,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    stall,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    exc_misalign,
  output logic                    exc_timeout
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int OW = off_width(DATA_WIDTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  squash;
  logic [ADDR_WIDTH-1:0] addr_q;
  bus_dir_e              dir_q;
  logic [BW-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, ld_data;
  size_e                 size_q;
  logic                  sign_q;
  logic [OW-1:0]         off_q;
  logic                  misalign_q, timeout_q;

  logic                  accept, misalign, start, timed_out;
  logic [3:0]            amask;
  logic [7:0]            sel_base;
  logic [OW-1:0]         req_off;

  assign req_off = req_addr[OW-1:0];
  assign accept  = (state == ST_IDLE) && req_valid && (req_read ^ req_write) && !flush;
  assign start   = accept && !misalign;
  // Wait count reaches TIMEOUT on this cycle; an ack in the same cycle wins.
  assign timed_out = (state == ST_BUS) && !bus_ack && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    amask    = (4'd1 << req_size) - 4'd1;
    misalign = (|(req_addr[2:0] & amask[2:0])) ||
               ((DATA_WIDTH == 32) && (req_size == 2'd3));
    sel_base = 8'h00;
    case (size_e'(req_size))
      SZ_BYTE:  sel_base = 8'h01;
      SZ_HALF:  sel_base = 8'h03;
      SZ_WORD:  sel_base = 8'h0F;
      SZ_DWORD: sel_base = 8'hFF;
      default:  sel_base = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_BUS;
      ST_BUS: begin
        if (bus_ack)        state_nxt = ST_RESP;
        else if (timed_out) state_nxt = ST_IDLE;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      squash     <= 1'b0;
      addr_q     <= '0;
      dir_q      <= BUS_RD;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= SZ_BYTE;
      sign_q     <= 1'b0;
      off_q      <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      misalign_q <= accept && misalign;
      timeout_q  <= timed_out && !(squash || flush);
      if (start) begin
        addr_q  <= {req_addr[ADDR_WIDTH-1:OW], OW'(0)};
        dir_q   <= req_write ? BUS_WR : BUS_RD;
        sel_q   <= BW'(sel_base) << req_off;
        wdata_q <= req_wdata << {req_off, 3'b000};
        size_q  <= size_e'(req_size);
        sign_q  <= req_sign;
        off_q   <= req_off;
        cnt     <= '0;
        squash  <= 1'b0;
      end else if (state == ST_BUS) begin
        if (!bus_ack) cnt <= cnt + CW'(1);
        if (flush)    squash <= 1'b1;
        if (bus_ack)  rdata_q <= (dir_q == BUS_WR) ? '0 : ld_data;
      end
    end
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH), .OFF_W(OW)) u_load_align (
    .rdata (bus_rdata),
    .off   (off_q),
    .size  (size_q),
    .sign  (sign_q),
    .data  (ld_data)
  );

  // Bus outputs are forced low outside BUS so reset and idle look identical.
  assign bus_req      = (state == ST_BUS);
  assign bus_we       = bus_req && (dir_q == BUS_WR);
  assign bus_addr     = bus_req ? addr_q  : '0;
  assign bus_sel      = bus_req ? sel_q   : '0;
  assign bus_wdata    = bus_req ? wdata_q : '0;
  assign stall        = rst && (bus_req || start);
  assign rsp_valid    = (state == ST_RESP) && !squash && !flush;
  assign rsp_rdata    = rdata_q;
  assign exc_misalign = misalign_q;
  assign exc_timeout  = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: a table of single-access vectors on a 32-bit instance plus
// hand sequences for wait states, timeout, flush and a 64-bit instance.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_read, req_write, req_sign, flush, bus_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, bus_rdata;
  logic [63:0] wdata64, rdata64;

  logic        bus_req, bus_we, stall, rsp_valid, exc_misalign, exc_timeout;
  logic [31:0] bus_addr, bus_wdata, rsp_rdata;
  logic [3:0]  bus_sel;

  logic        bus_req64, bus_we64, stall64, rsp_valid64, exc_misalign64, exc_timeout64;
  logic [31:0] bus_addr64;
  logic [63:0] bus_wdata64, rsp_rdata64;
  logic [7:0]  bus_sel64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign wdata64 = {32'h0, req_wdata};

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_sign(req_sign), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
  );

  mem_access_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(4)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_sign(req_sign), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(wdata64), .flush(flush),
    .bus_req(bus_req64), .bus_we(bus_we64), .bus_addr(bus_addr64), .bus_sel(bus_sel64),
    .bus_wdata(bus_wdata64), .bus_ack(bus_ack), .bus_rdata(rdata64),
    .stall(stall64), .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64),
    .exc_misalign(exc_misalign64), .exc_timeout(exc_timeout64)
  );

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, rdata;
    logic        go, mis;
    logic [3:0]  sel;
    logic [31:0] bwdata, rsp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic sgn,
                           input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_sign = sgn;
    req_size = sz; req_addr = addr; req_wdata = wdata;
  endtask

  // One access with ack on the first BUS cycle; starts and ends on a negedge.
  task automatic run_vec(input int i, input vec_t v);
    drive_req(v.rd, v.wr, v.sgn, v.sz, v.addr, v.wdata);
    #1 chk($sformatf("v%0d stall", i), stall, v.go);
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("v%0d bus_req", i), bus_req, v.go);
    chk($sformatf("v%0d exc_misalign", i), exc_misalign, v.mis);
    if (v.go) begin
      chk($sformatf("v%0d bus_we", i), bus_we, v.wr);
      chk($sformatf("v%0d bus_addr", i), bus_addr, v.addr & ~32'h3);
      chk($sformatf("v%0d bus_sel", i), bus_sel, v.sel);
      chk($sformatf("v%0d bus_wdata", i), bus_wdata, v.bwdata);
      bus_ack = 1'b1; bus_rdata = v.rdata;
      @(negedge clk);
      bus_ack = 1'b0;
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, 1'b1);
      chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, v.rsp);
      chk($sformatf("v%0d resp stall", i), stall, 1'b0);
    end
    @(negedge clk);
    chk($sformatf("v%0d idle rsp_valid", i), rsp_valid, 1'b0);
    chk($sformatf("v%0d idle exc_misalign", i), exc_misalign, 1'b0);
    chk($sformatf("v%0d idle bus_req", i), bus_req, 1'b0);
  endtask

  initial begin
    //            rd wr sg sz     addr          wdata         rdata         go mis sel      bwdata        rsp
    vecs[0]  = '{1, 0, 1, 2'd1, 32'h0000_0102, 32'h0000_0000, 32'h8001_0000, 1, 0, 4'b1100, 32'h0000_0000, 32'hFFFF_8001};
    vecs[1]  = '{1, 0, 0, 2'd0, 32'h0000_0101, 32'h0000_0000, 32'h1234_8056, 1, 0, 4'b0010, 32'h0000_0000, 32'h0000_0080};
    vecs[2]  = '{1, 0, 1, 2'd0, 32'h0000_0101, 32'h0000_0000, 32'h1234_8056, 1, 0, 4'b0010, 32'h0000_0000, 32'hFFFF_FF80};
    vecs[3]  = '{1, 0, 0, 2'd2, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4]  = '{1, 0, 0, 2'd1, 32'h0000_0100, 32'h0000_0000, 32'h1234_ABCD, 1, 0, 4'b0011, 32'h0000_0000, 32'h0000_ABCD};
    vecs[5]  = '{0, 1, 0, 2'd0, 32'h0000_0203, 32'h0000_00AB, 32'h5555_5555, 1, 0, 4'b1000, 32'hAB00_0000, 32'h0000_0000};
    vecs[6]  = '{0, 1, 0, 2'd1, 32'h0000_0202, 32'h0000_BEEF, 32'h5555_5555, 1, 0, 4'b1100, 32'hBEEF_0000, 32'h0000_0000};
    vecs[7]  = '{0, 1, 0, 2'd2, 32'h0000_0204, 32'h1122_3344, 32'h5555_5555, 1, 0, 4'b1111, 32'h1122_3344, 32'h0000_0000};
    vecs[8]  = '{1, 0, 0, 2'd2, 32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 0, 1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1, 0, 1, 2'd1, 32'h0000_0103, 32'h0000_0000, 32'h0000_0000, 0, 1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{1, 1, 0, 2'd2, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{1, 0, 0, 2'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1, 4'b0000, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b0; req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_sign = 1'b0;
    req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'h0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0; rdata64 = 64'h0;
    repeat (2) @(negedge clk);
    chk("reset bus_req", bus_req, 1'b0);
    chk("reset stall", stall, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset bus_sel", bus_sel, 4'h0);
    chk("reset exc", {exc_misalign, exc_timeout}, 2'b00);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Store held stable over three wait cycles, acked on the fourth.
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 2'd0, 32'h203, 32'h0000_00AB);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sb w%0d bus_req", k), bus_req, 1'b1);
      chk($sformatf("sb w%0d bus_we", k), bus_we, 1'b1);
      chk($sformatf("sb w%0d bus_addr", k), bus_addr, 32'h200);
      chk($sformatf("sb w%0d bus_sel", k), bus_sel, 4'b1000);
      chk($sformatf("sb w%0d bus_wdata", k), bus_wdata, 32'hAB00_0000);
      chk($sformatf("sb w%0d stall", k), stall, 1'b1);
      if (k == 3) bus_ack = 1'b1;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    chk("sb rsp_valid", rsp_valid, 1'b1);
    chk("sb rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);

    // Timeout: no ack ever.
    begin
      int hi;
      hi = 0;
      drive_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h300, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 10 && bus_req; k++) begin
        hi++;
        chk("to rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
      end
      chk("to bus_req cycles", hi, 4);
      chk("to exc_timeout", exc_timeout, 1'b1);
      chk("to no rsp", rsp_valid, 1'b0);
      @(negedge clk);
      chk("to pulse end", exc_timeout, 1'b0);
      chk("to idle", bus_req, 1'b0);
    end

    // Flush during BUS squashes the response; the bus cycle still completes.
    drive_req(1'b1, 1'b0, 1'b0, 2'd0, 32'h101, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    chk("fl bus_req", bus_req, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    chk("fl still bus", bus_req, 1'b1);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h0000_8000;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("fl rsp_valid", rsp_valid, 1'b0);
    chk("fl resp no bus", bus_req, 1'b0);
    @(negedge clk);
    run_vec(100, vecs[1]);

    // Flush in IDLE blocks acceptance.
    drive_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    flush = 1'b1;
    #1 chk("fi stall", stall, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("fi bus_req", bus_req, 1'b0);

    // Flush in RESP suppresses rsp_valid.
    drive_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1;
    @(negedge clk);
    bus_ack = 1'b0; flush = 1'b1;
    #1 chk("fr rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0;

    // Ack while idle is ignored.
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("ia rsp_valid", rsp_valid, 1'b0);
    chk("ia bus_req", bus_req, 1'b0);

    // 64-bit instance: dword and upper-word loads, then reset mid-BUS.
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 2'd3, 32'h8, 32'h0);
    #1 chk("d64 stall", stall64, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("d64 bus_req", bus_req64, 1'b1);
    chk("d64 bus_sel", bus_sel64, 8'hFF);
    chk("d64 bus_addr", bus_addr64, 32'h8);
    bus_ack = 1'b1; rdata64 = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("d64 rsp_valid", rsp_valid64, 1'b1);
    chk("d64 rsp_rdata", rsp_rdata64, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b1, 2'd2, 32'hC, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("w64 bus_sel", bus_sel64, 8'hF0);
    chk("w64 bus_addr", bus_addr64, 32'h8);
    bus_ack = 1'b1; rdata64 = 64'h8765_4321_0000_0000;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("w64 rsp_rdata", rsp_rdata64, 64'hFFFF_FFFF_8765_4321);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rb bus_req before", bus_req64, 1'b1);
    rst = 1'b0;
    #1 chk("rb bus_req64 drop", bus_req64, 1'b0);
    chk("rb bus_req drop", bus_req, 1'b0);
    chk("rb stall64", stall64, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rb c%0d rsp_valid64", k), rsp_valid64, 1'b0);
      chk($sformatf("rb c%0d bus_req64", k), bus_req64, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
